my_serial_sub_16: RTL and testbench



---
 rtl/my_serial_sub_pkg.sv | 15 +
 rtl/my_serial_sub_16_my_sub_bit.sv | 16 +
 rtl/my_serial_sub_16.sv | 130 +++++++++++++
 tb/tb_my_serial_sub_16.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/my_serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package my_serial_sub_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Legal WIDTH range, enforced at elaboration.
    localparam int MY_SUB_MIN_WIDTH = 2;
    localparam int MY_SUB_MAX_WIDTH = 32;

endpackage

// File: rtl/my_serial_sub_16_my_sub_bit.sv
// One-bit subtract cell: diff = a - b - bin, with borrow out.
module my_sub_bit (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    // Full-subtractor equations.
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/my_serial_sub_16.sv
// Bit-serial a - b (mod 2^WIDTH), LSB first, one bit per clock behind
// valid/ready handshakes. Define MY_SERIAL_SUB_FLAGS_EN to add the
// borrow/zero/neg result flags.
module my_serial_sub_16
    import my_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef MY_SERIAL_SUB_FLAGS_EN
    ,
    output logic             borrow,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < MY_SUB_MIN_WIDTH || WIDTH > MY_SUB_MAX_WIDTH) begin : g_bad_width
            $error("my_serial_sub_16: WIDTH out of range");
        end
    endgenerate

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]   cnt;
    logic            bin_q;
    logic            load, shift;
    logic            diff, bout;

    // Single shared cell; the borrow flop carries between bits.
    my_sub_bit u_bit (
        .diff (diff),
        .bout (bout),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state, handshake outputs and datapath strobes.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                shift = 1'b1;
                if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters, result shifter, borrow flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            bin_q <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            cnt   <= '0;
            bin_q <= 1'b0;
        end else if (shift) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= {diff, res[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            bin_q <= bout;
        end
    end

    assign out = res;

`ifdef MY_SERIAL_SUB_FLAGS_EN
    logic zero_q, neg_q;

    // Capture zero/neg from the completed result on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (shift && cnt == LAST) begin
            zero_q <= ({diff, res[WIDTH-1:1]} == '0);
            neg_q  <= diff;
        end
    end

    // The borrow flop is frozen outside S_BUSY, so after the last bit it
    // already holds the final borrow.
    assign borrow = bin_q;
    assign zero   = zero_q;
    assign neg    = neg_q;
`endif

endmodule

// File: tb/tb_my_serial_sub_16.sv
// Directed and random checks for my_serial_sub_16 (WIDTH = 16).
module tb_my_serial_sub_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out;
`ifdef MY_SERIAL_SUB_FLAGS_EN
    logic        borrow, zero, neg;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    my_serial_sub_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef MY_SERIAL_SUB_FLAGS_EN
        ,
        .borrow    (borrow),
        .zero      (zero),
        .neg       (neg)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Present operands once in_ready is seen, hold through one edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, output int acc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1; a = av; b = bv;
        @(posedge clk);
        acc = cyc;
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept until out_valid; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out !== 16'h0) begin failures++; $display("FAIL reset_out got %h want 0000", out); end
`ifdef MY_SERIAL_SUB_FLAGS_EN
        checks++; if ({borrow, zero, neg} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {borrow, zero, neg}); end
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int acc, lat;
        // 5 - 3
        start_op(16'd5, 16'd3, acc);
        wait_done(lat);
        checks++; if (lat !== 16) begin failures++; $display("FAIL latency got %0d want 16", lat); end
        checks++; if (out !== 16'h0002) begin failures++; $display("FAIL sub_5_3 got %h want 0002", out); end
`ifdef MY_SERIAL_SUB_FLAGS_EN
        checks++; if ({borrow, zero, neg} !== 3'b000) begin failures++; $display("FAIL flags_5_3 got %b want 000", {borrow, zero, neg}); end
`endif
        finish_op();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL complete got ov=%0b ir=%0b want 0 1", out_valid, in_ready); end
        // 3 - 5 wraps
        start_op(16'd3, 16'd5, acc);
        wait_done(lat);
        checks++; if (out !== 16'hFFFE) begin failures++; $display("FAIL sub_3_5 got %h want fffe", out); end
`ifdef MY_SERIAL_SUB_FLAGS_EN
        checks++; if ({borrow, zero, neg} !== 3'b101) begin failures++; $display("FAIL flags_3_5 got %b want 101", {borrow, zero, neg}); end
`endif
        finish_op();
        // equal operands
        start_op(16'h1234, 16'h1234, acc);
        wait_done(lat);
        checks++; if (out !== 16'h0000) begin failures++; $display("FAIL sub_eq got %h want 0000", out); end
`ifdef MY_SERIAL_SUB_FLAGS_EN
        checks++; if ({borrow, zero, neg} !== 3'b010) begin failures++; $display("FAIL flags_eq got %b want 010", {borrow, zero, neg}); end
`endif
        finish_op();
        // 0x8000 - 1
        start_op(16'h8000, 16'h0001, acc);
        wait_done(lat);
        checks++; if (out !== 16'h7FFF) begin failures++; $display("FAIL sub_8000_1 got %h want 7fff", out); end
`ifdef MY_SERIAL_SUB_FLAGS_EN
        checks++; if ({borrow, zero, neg} !== 3'b000) begin failures++; $display("FAIL flags_8000_1 got %b want 000", {borrow, zero, neg}); end
`endif
        finish_op();
    endtask

    task automatic test_hold();
        int acc, lat;
        start_op(16'h00F0, 16'h000F, acc);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; a = a ^ 16'hA5A5; b = b + 16'd7;
            @(posedge clk); #1;
            checks++; if (out !== 16'h00E1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++; $display("FAIL hold_%0d got out=%h ov=%0b ir=%0b want 00e1 1 0", i, out, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got ov=%0b ir=%0b want 0 1", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_single got ov=%0b ir=%0b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int acc, lat;
        start_op(16'h1111, 16'h0101, acc);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out !== 16'h0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got ov=%0b out=%h ir=%0b want 0 0000 1", out_valid, out, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        start_op(16'd10, 16'd4, acc);
        wait_done(lat);
        checks++; if (out !== 16'd6 || lat !== 16) begin failures++; $display("FAIL after_reset got out=%h lat=%0d want 0006 16", out, lat); end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int acc, prev, lat, errs, serrs;
        logic [15:0] av, bv, exp;
        errs = 0; serrs = 0; prev = -1000;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            av = 16'($urandom); bv = 16'($urandom);
            if (i == 0) begin av = 16'h0000; bv = 16'hFFFF; end
            exp = av - bv;
            start_op(av, bv, acc);
            if (acc - prev < 18) serrs++;
            prev = acc;
            wait_done(lat);
            if (out !== exp || lat !== 16) errs++;
`ifdef MY_SERIAL_SUB_FLAGS_EN
            if (borrow !== (av < bv) || zero !== (exp == 16'h0) || neg !== exp[15]) errs++;
`endif
            if (errs == 1 && (out !== exp)) $display("FAIL b2b_first a=%h b=%h got %h want %h", av, bv, out, exp);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (errs !== 0) begin failures++; $display("FAIL b2b_results got %0d errors want 0", errs); end
        checks++; if (serrs !== 0) begin failures++; $display("FAIL b2b_spacing got %0d short gaps want 0", serrs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
